// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package if_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        STALL = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/if_perf_cnt.sv
// Saturating event counter used for fetch-stage performance statistics.
module if_perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and schedules IF/ID write/flush/valid.
// Optional performance counters are built when IF_FETCH_PERF_EN is defined.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter logic [PC_W-1:0] PC_STEP       = 32'd4,
    parameter int unsigned     BOOT_CYCLES   = 2,
    parameter int unsigned     FLUSH_BUBBLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_req,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    input  logic            halt_req,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next_seq,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic            fetch_valid,
    output logic            misalign_err,
    output logic [2:0]      fsm_state
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_cycles,
    output logic [31:0]     redirect_count
`endif
);

    localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_BUBBLES - 1);

    fetch_state_t state;
    logic [3:0]   boot_cnt;
    logic [2:0]   flush_cnt;
    logic         active;
    logic         redirect_take;
    logic         halt_take;
    logic         stall_take;

    assign pc_next_seq = pc + PC_STEP;
    assign fsm_state   = state;

    // Illegal encodings behave like BOOT: no request is accepted.
    assign active        = state inside {RUN, STALL, FLUSH, HALT};
    assign redirect_take = redirect_valid && active;
    assign halt_take     = halt_req && !redirect_valid && (state inside {RUN, STALL});
    assign stall_take    = stall_req && !redirect_valid && !halt_req
                           && (state inside {RUN, STALL});

    always_comb begin
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        fetch_valid = 1'b0;
        case (state)
            RUN, STALL: begin
                if (redirect_take || halt_take) begin
                    ifid_write = 1'b1;
                    ifid_flush = 1'b1;
                end else if (stall_take) begin
                    fetch_valid = 1'b1;
                end else begin
                    ifid_write  = 1'b1;
                    fetch_valid = 1'b1;
                end
            end
            FLUSH, HALT: begin
                ifid_write = 1'b1;
                ifid_flush = 1'b1;
            end
            default: ifid_flush = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= RESET_PC;
            state        <= BOOT;
            boot_cnt     <= '0;
            flush_cnt    <= '0;
            misalign_err <= 1'b0;
        end else if (redirect_take) begin
            pc        <= {redirect_target[PC_W-1:2], 2'b00};
            flush_cnt <= FLUSH_LOAD;
            state     <= (FLUSH_BUBBLES == 1) ? RUN : FLUSH;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        state <= RUN;
                    end else begin
                        boot_cnt <= boot_cnt + 4'd1;
                    end
                end
                RUN, STALL: begin
                    if (halt_take) begin
                        state <= HALT;
                    end else if (stall_take) begin
                        state <= STALL;
                    end else begin
                        pc    <= pc_next_seq;
                        state <= RUN;
                    end
                end
                FLUSH: begin
                    // flush_cnt holds the FLUSH cycles still to run, this one included.
                    pc        <= pc_next_seq;
                    flush_cnt <= flush_cnt - 3'd1;
                    if (flush_cnt <= 3'd1) begin
                        state <= RUN;
                    end
                end
                HALT: state <= HALT;
                default: begin
                    state    <= BOOT;
                    boot_cnt <= '0;
                end
            endcase
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = (state == STALL);
    assign flush_evt = ifid_flush && active;

    if_perf_cnt #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (stall_evt),
        .count (stall_cycles)
    );

    if_perf_cnt #(.W(32)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (flush_evt),
        .count (flush_cycles)
    );

    if_perf_cnt #(.W(32)) u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (redirect_take),
        .count (redirect_count)
    );
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: a behavioural fetch model predicts each
// cycle's outputs, a separate monitor compares them against the DUT.
module tb_if_fetch_ctrl;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam int unsigned T_BOOT     = 2;
    localparam int unsigned T_BUBBLES  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        halt_req = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        ifid_write;
    logic        ifid_flush;
    logic        fetch_valid;
    logic        misalign_err;
    logic [2:0]  fsm_state;

    if_fetch_ctrl #(
        .RESET_PC      (T_RESET_PC),
        .PC_STEP       (32'd4),
        .BOOT_CYCLES   (T_BOOT),
        .FLUSH_BUBBLES (T_BUBBLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_req       (stall_req),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .pc              (pc),
        .pc_next_seq     (pc_next_seq),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .fetch_valid     (fetch_valid),
        .misalign_err    (misalign_err),
        .fsm_state       (fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] nseq;
        logic        w;
        logic        f;
        logic        v;
        logic        mis;
        logic [2:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: plain bookkeeping of what the fetch stage is doing.
    logic [31:0] m_pc;
    int          boot_left;
    int          flush_left;
    bit          halted;
    bit          stalled;
    bit          m_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = T_RESET_PC;
        boot_left  = T_BOOT;
        flush_left = 0;
        halted     = 0;
        stalled    = 0;
        m_mis      = 0;
    endtask

    task automatic model_step(input bit s, input bit r, input logic [31:0] t, input bit h,
                              output exp_t e);
        e.pc   = m_pc;
        e.nseq = m_pc + 32'd4;
        e.mis  = m_mis;
        e.st   = (boot_left > 0) ? 3'd0 : halted ? 3'd4 : (flush_left > 0) ? 3'd3 :
                 stalled ? 3'd2 : 3'd1;
        if (boot_left > 0) begin
            {e.w, e.f, e.v} = 3'b010;
            boot_left--;
        end else if (r) begin
            {e.w, e.f, e.v} = 3'b110;
            m_pc       = t & 32'hFFFF_FFFC;
            m_mis      = m_mis | (t[1:0] != 2'b00);
            flush_left = T_BUBBLES - 1;
            halted     = 0;
            stalled    = 0;
        end else if (halted) begin
            {e.w, e.f, e.v} = 3'b110;
        end else if (flush_left > 0) begin
            {e.w, e.f, e.v} = 3'b110;
            m_pc = m_pc + 32'd4;
            flush_left--;
        end else if (h) begin
            {e.w, e.f, e.v} = 3'b110;
            halted  = 1;
            stalled = 0;
        end else if (s) begin
            {e.w, e.f, e.v} = 3'b001;
            stalled = 1;
        end else begin
            {e.w, e.f, e.v} = 3'b101;
            m_pc    = m_pc + 32'd4;
            stalled = 0;
        end
    endtask

    // Called at posedge+1: sets inputs for the cycle and queues its expected outputs.
    task automatic drive(input bit s, input bit r, input logic [31:0] t, input bit h);
        exp_t e;
        stall_req       = s;
        redirect_valid  = r;
        redirect_target = t;
        halt_req        = h;
        model_step(s, r, t, h, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_running(input logic [31:0] at_pc);
        return boot_left == 0 && flush_left == 0 && !halted && m_pc == at_pc;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("pc_next_seq", pc_next_seq, e.nseq);
                check("ifid_write", 32'(ifid_write), 32'(e.w));
                check("ifid_flush", 32'(ifid_flush), 32'(e.f));
                check("fetch_valid", 32'(fetch_valid), 32'(e.v));
                check("misalign_err", 32'(misalign_err), 32'(e.mis));
                check("fsm_state", 32'(fsm_state), 32'(e.st));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] t;
        int unsigned sel;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_pc", pc, T_RESET_PC);
        check("rst_state", 32'(fsm_state), 32'd0);
        check("rst_ctrl", 32'({ifid_write, ifid_flush, fetch_valid}), 32'b010);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 40 && !model_running(32'h10); i++) drive(0, 0, '0, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, '0, 0);
        for (int i = 0; i < 40 && !model_running(32'h20); i++) drive(0, 0, '0, 0);
        drive(1, 1, 32'h100, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, '0, 0);
        drive(0, 1, 32'h103, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, '0, 0);
        drive(0, 1, 32'h38, 0);
        for (int i = 0; i < 40 && !model_running(32'h40); i++) drive(0, 0, '0, 0);
        drive(0, 0, '0, 1);
        for (int i = 0; i < 6; i++) drive(1'($urandom_range(0, 1)), 0, '0, 1'($urandom_range(0, 1)));
        drive(0, 1, 32'h200, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, '0, 0);
        drive(0, 1, 32'hFFFF_FFFC, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, '0, 0);
        drive(0, 1, 32'h500, 0);

        // DUT now sits in FLUSH; reset must take effect without a clock edge.
        check("pre_reset_flush_state", 32'(fsm_state), 32'd3);
        #1 rst = 1'b0;
        #1;
        check("async_rst_pc", pc, T_RESET_PC);
        check("async_rst_state", 32'(fsm_state), 32'd0);
        check("async_rst_misalign", 32'(misalign_err), 32'd0);
        check("async_rst_ctrl", 32'({ifid_write, ifid_flush, fetch_valid}), 32'b010);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        for (int i = 0; i < 600; i++) begin
            t   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 7) t[1:0] = 2'b00;
            if (sel == 9) t = 32'hFFFF_FFF0 | (t & 32'h0000_000C);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, t,
                  $urandom_range(0, 19) == 0);
        end
        drive(0, 0, '0, 0);

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
